// File: rtl/muldiv_unit_if.sv
// Request/response bundle between an issue stage and the iterative multiply/divide unit.
// The unit is the slave; the issuing stage (or a bench) is the master.
interface muldiv_unit_if #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 5
);
    logic                    start_i;
    logic [2:0]              op_i;
    logic [DataWidth-1:0]    rs1_data_i;
    logic [DataWidth-1:0]    rs2_data_i;
    logic [AddressWidth-1:0] rd_addr_i;
    logic                    busy_o;
    logic                    done_o;
    logic [DataWidth-1:0]    result_o;
    logic [AddressWidth-1:0] rd_addr_o;
    logic                    wr_en_o;
    logic                    illegal_o;

    modport master (
        output start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i,
        input  busy_o, done_o, result_o, rd_addr_o, wr_en_o, illegal_o
    );

    modport slave (
        input  start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i,
        output busy_o, done_o, result_o, rd_addr_o, wr_en_o, illegal_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiply and restoring divide.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU/REM/REMU complete as illegal.
module muldiv_unit #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 5
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    muldiv_unit_if.slave bus
);
    localparam int CntW = $clog2(DataWidth);
    localparam logic [DataWidth-1:0] MinVal = {1'b1, {(DataWidth-1){1'b0}}};

`ifdef MULDIV_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
`else
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;
`endif

    function automatic logic [DataWidth-1:0] neg_w(input logic [DataWidth-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [DataWidth-1:0] mag(input logic [DataWidth-1:0] v, input logic sgn);
        return neg_w(v, sgn & v[DataWidth-1]);
    endfunction

    state_e                  state_q;
    logic [CntW-1:0]         cnt_q;
    logic [DataWidth-1:0]    hi_q, lo_q, b_q;
    logic [1:0]              op_q;
    logic                    neg_q;
    logic [AddressWidth-1:0] rd_pend_q;
    logic                    done_q, wr_en_q, illegal_q;
    logic [DataWidth-1:0]    result_q;
    logic [AddressWidth-1:0] rd_addr_q;

    // Multiply step: hi accumulates the multiplicand, {hi,lo} shifts right as lo's bits are consumed.
    logic                     a_sgn, b_sgn;
    logic [DataWidth-1:0]     addend_d, mul_hi_d, mul_lo_d, mul_res_d;
    logic [DataWidth:0]       sum_d;
    logic [2*DataWidth-1:0]   prod_d;

    always_comb begin
        a_sgn     = (bus.op_i == 3'b001) || (bus.op_i == 3'b010);
        b_sgn     = (bus.op_i == 3'b001);
        addend_d  = lo_q[0] ? b_q : '0;
        sum_d     = {1'b0, hi_q} + {1'b0, addend_d};
        mul_hi_d  = sum_d[DataWidth:1];
        mul_lo_d  = {sum_d[0], lo_q[DataWidth-1:1]};
        prod_d    = neg_q ? -{mul_hi_d, mul_lo_d} : {mul_hi_d, mul_lo_d};
        mul_res_d = (op_q == 2'b00) ? prod_d[DataWidth-1:0] : prod_d[2*DataWidth-1:DataWidth];
    end

`ifdef MULDIV_DIV_EN
    // Divide step: hi is the partial remainder, lo shifts the dividend out and the quotient in.
    logic                 rneg_q;
    logic                 d_sgn, div_zero, div_ovf, qbit_d;
    logic [DataWidth:0]   shl_d, diff_d;
    logic [DataWidth-1:0] div_hi_d, div_lo_d, div_res_d;

    always_comb begin
        d_sgn     = ~bus.op_i[0];
        div_zero  = (bus.rs2_data_i == '0);
        div_ovf   = d_sgn && (bus.rs1_data_i == MinVal) && (bus.rs2_data_i == '1);
        shl_d     = {hi_q, lo_q[DataWidth-1]};
        diff_d    = shl_d - {1'b0, b_q};
        qbit_d    = ~diff_d[DataWidth];
        div_hi_d  = qbit_d ? diff_d[DataWidth-1:0] : shl_d[DataWidth-1:0];
        div_lo_d  = {lo_q[DataWidth-2:0], qbit_d};
        div_res_d = op_q[1] ? neg_w(div_hi_d, rneg_q) : neg_w(div_lo_d, neg_q);
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
            rneg_q    <= 1'b0;
`endif
            rd_pend_q <= '0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            result_q  <= '0;
            rd_addr_q <= '0;
        end else begin
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                MUL: begin
                    hi_q  <= mul_hi_d;
                    lo_q  <= mul_lo_d;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        result_q  <= mul_res_d;
                        rd_addr_q <= rd_pend_q;
                        wr_en_q   <= (rd_pend_q != '0);
                    end
                end
`ifdef MULDIV_DIV_EN
                DIV: begin
                    hi_q  <= div_hi_d;
                    lo_q  <= div_lo_d;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        result_q  <= div_res_d;
                        rd_addr_q <= rd_pend_q;
                        wr_en_q   <= (rd_pend_q != '0);
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    if (bus.start_i) begin
                        rd_pend_q <= bus.rd_addr_i;
                        op_q      <= bus.op_i[1:0];
                        hi_q      <= '0;
                        cnt_q     <= CntW'(DataWidth - 1);
                        if (!bus.op_i[2]) begin
                            state_q <= MUL;
                            b_q     <= mag(bus.rs1_data_i, a_sgn);
                            lo_q    <= mag(bus.rs2_data_i, b_sgn);
                            neg_q   <= (a_sgn & bus.rs1_data_i[DataWidth-1]) ^
                                       (b_sgn & bus.rs2_data_i[DataWidth-1]);
                        end
`ifdef MULDIV_DIV_EN
                        // Zero divisor and signed overflow have closed-form results; skip iterating.
                        else if (div_zero || div_ovf) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            rd_addr_q <= bus.rd_addr_i;
                            wr_en_q   <= (bus.rd_addr_i != '0);
                            if (div_zero)
                                result_q <= bus.op_i[1] ? bus.rs1_data_i : '1;
                            else
                                result_q <= bus.op_i[1] ? '0 : bus.rs1_data_i;
                        end else begin
                            state_q <= DIV;
                            lo_q    <= mag(bus.rs1_data_i, d_sgn);
                            b_q     <= mag(bus.rs2_data_i, d_sgn);
                            neg_q   <= d_sgn & (bus.rs1_data_i[DataWidth-1] ^ bus.rs2_data_i[DataWidth-1]);
                            rneg_q  <= d_sgn & bus.rs1_data_i[DataWidth-1];
                        end
`else
                        else begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            illegal_q <= 1'b1;
                            rd_addr_q <= bus.rd_addr_i;
                            result_q  <= '0;
                        end
`endif
                    end
                end
            endcase
        end
    end

`ifdef MULDIV_DIV_EN
    assign bus.busy_o = (state_q == MUL) || (state_q == DIV);
`else
    assign bus.busy_o = (state_q == MUL);
`endif
    assign bus.done_o    = done_q;
    assign bus.result_o  = result_q;
    assign bus.rd_addr_o = rd_addr_q;
    assign bus.wr_en_o   = wr_en_q;
    assign bus.illegal_o = illegal_q;
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter DataWidth, default 32, operand/result width in bits.
REQ-002 Parameter AddressWidth, default 5, destination register address width.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  request to begin an operation.
REQ-006 op_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 rs1_data_i  input  DataWidth  operand A, from register-file rs1 read port.
REQ-008 rs2_data_i  input  DataWidth  operand B, from register-file rs2 read port.
REQ-009 rd_addr_i  input  AddressWidth  destination register of the request.
REQ-010 busy_o  output  1  operation in progress; new requests not accepted.
REQ-011 done_o  output  1  one-cycle pulse; result_o and rd_addr_o valid.
REQ-012 result_o  output  DataWidth  registered result.
REQ-013 rd_addr_o  output  AddressWidth  destination captured at accept.
REQ-014 wr_en_o  output  1  register-file write enable: done_o AND (rd_addr_o != 0).
REQ-015 illegal_o  output  1  pulses with done_o when op is not supported by this build.

Function
REQ-016 FSM states IDLE, MUL, DIV, DONE; busy_o SHALL be 1 only in MUL and DIV.
REQ-017 A request SHALL be accepted on a rising edge where start_i=1 and state is IDLE or DONE; op_i, both operands and rd_addr_i are latched at that edge.
REQ-018 start_i while busy_o=1 SHALL be ignored, with no effect on the operation in progress.
REQ-019 Input changes after acceptance SHALL NOT affect the result.
REQ-020 MUL-class ops: shift-add, one bit per cycle, DataWidth cycles in MUL state, then DONE; done_o at cycle k+DataWidth+1 for acceptance edge k.
REQ-021 MUL returns low DataWidth bits of the 2*DataWidth product; MULH signed x signed, MULHSU signed rs1 x unsigned rs2, MULHU unsigned x unsigned; all three return the high DataWidth bits.
REQ-022 DIV-class ops: restoring division on magnitudes, DataWidth cycles in DIV state, then DONE; same latency as REQ-020.
REQ-023 Signed quotient SHALL be truncated toward zero; remainder SHALL take the sign of the dividend.
REQ-024 Divide by zero: state IDLE/DONE -> DONE directly, done_o at k+1; DIV/DIVU return all ones, REM/REMU return rs1.
REQ-025 Signed overflow (rs1 = most negative value, rs2 = -1): done_o at k+1; DIV returns rs1, REM returns 0.
REQ-026 DONE lasts exactly one cycle; the next state is IDLE, or MUL/DIV/DONE if a new request is accepted on that edge (back-to-back).
REQ-027 result_o and rd_addr_o SHALL hold their values until the next done_o.

Reset
REQ-028 rst_ni=0 SHALL asynchronously force state IDLE, busy_o=0, done_o=0, wr_en_o=0, illegal_o=0, result_o=0, rd_addr_o=0, and clear all iteration registers.
REQ-029 Reset mid-operation SHALL abandon the operation with no done_o; the first request after release behaves as from power-up.

Configuration
REQ-030 Macro MULDIV_DIV_EN defined: DIV/DIVU/REM/REMU implemented per REQ-022..025; illegal_o stays 0.
REQ-031 Macro MULDIV_DIV_EN undefined: no divider logic and no DIV state; op_i[2]=1 requests go straight to DONE with done_o at k+1, result_o=0, wr_en_o=0, illegal_o=1.

Verification
REQ-032 MUL rs1=7, rs2=-3, rd=5 -> done_o at k+33, result_o=0xFFFFFFEB, wr_en_o=1, rd_addr_o=5.
REQ-033 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 DIV -7/2 -> -3, REM -7/2 -> -1, DIVU 0x80000000/0x10 -> 0x08000000; each with done_o at k+33.
REQ-035 DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000; each with done_o at k+1.
REQ-036 start_i held high with changing operands during busy_o -> single result from the latched operands; new request accepted in the DONE cycle -> back-to-back completion, no idle cycle.
REQ-037 rst_ni low at cycle k+10 of a MUL -> all outputs 0 immediately, no done_o; MUL rd=0 -> done_o=1, wr_en_o=0.
